// File: rtl/decode_control_issue_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : decode_control_issue_if                                  |
// | Brief  : Fetch-to-decode instruction handshake (valid/ready).     |
// | Rev    : 1.0  initial release                                     |
// +------------------------------------------------------------------+
interface decode_control_issue_if #(
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr;

    modport master (output in_valid, output instr, input in_ready);
    modport slave  (input in_valid, input instr, output in_ready);
endinterface
`default_nettype wire

// File: rtl/decode_control_issue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : decode_control_issue                                     |
// | Brief  : Decode-stage issue unit driving the Decode/Execute       |
// |          bundle; load-use bubbles, LDR2 split into two beats.     |
// |          Optional macro DCU_ILLEGAL_TRAP_EN: sticky illegal trap. |
// | Rev    : 1.0  initial release                                     |
// +------------------------------------------------------------------+
module decode_control_issue #(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 4,
    parameter int IMM_W   = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    decode_control_issue_if.slave   fetch,
    input  wire logic               ex_stall,
    input  wire logic               flush,
    output logic                    valid_out,
    output logic                    wbs_out,
    output logic                    wme_out,
    output logic                    mm_out,
    output logic [1:0]              ALUop_out,
    output logic                    wm_out,
    output logic                    am_out,
    output logic                    ni_out,
    output logic [REG_AW-1:0]       rd_out,
    output logic [REG_AW-1:0]       rs1_out,
    output logic [REG_AW-1:0]       rs2_out,
    output logic [IMM_W-1:0]        imm_out,
    output logic                    illegal_o
);

    localparam logic [3:0] c_OP_ADD  = 4'd1;
    localparam logic [3:0] c_OP_SUB  = 4'd2;
    localparam logic [3:0] c_OP_AND  = 4'd3;
    localparam logic [3:0] c_OP_ADDI = 4'd4;
    localparam logic [3:0] c_OP_LDR  = 4'd5;
    localparam logic [3:0] c_OP_STR  = 4'd6;
    localparam logic [3:0] c_OP_B    = 4'd7;
    localparam logic [3:0] c_OP_LDR2 = 4'd8;
    localparam logic [3:0] c_OP_OR   = 4'd9;

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_SECOND = 2'd1;
`ifdef DCU_ILLEGAL_TRAP_EN
    localparam logic [1:0] S_TRAP   = 2'd2;
`endif

    typedef struct packed {
        logic              valid;
        logic              wbs;
        logic              wme;
        logic              mm;
        logic [1:0]        aluop;
        logic              wm;
        logic              am;
        logic              ni;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [IMM_W-1:0]  imm;
    } bundle_t;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    bundle_t           r_out;
    bundle_t           w_out_nxt;
    bundle_t           w_dec;
    bundle_t           w_beat2;
    logic [3:0]        w_opc;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [IMM_W-1:0]  w_imm;
    logic              w_reads_rs1;
    logic              w_reads_rs2;
    logic              w_hazard;
    logic              w_in_ready;
    logic              w_accept;

    assign w_opc = fetch.instr[INSTR_W-1 -: 4];
    assign w_rd  = fetch.instr[24 +: REG_AW];
    assign w_rs1 = fetch.instr[20 +: REG_AW];
    assign w_rs2 = fetch.instr[16 +: REG_AW];
    assign w_imm = fetch.instr[0 +: IMM_W];

    always_comb begin
        w_dec       = '0;
        w_reads_rs1 = 1'b0;
        w_reads_rs2 = 1'b0;
        case (w_opc)
            c_OP_ADD:  begin w_dec.valid = 1'b1; w_dec.wbs = 1'b1; w_dec.aluop = 2'b00;
                             w_reads_rs1 = 1'b1; w_reads_rs2 = 1'b1; end
            c_OP_SUB:  begin w_dec.valid = 1'b1; w_dec.wbs = 1'b1; w_dec.aluop = 2'b01;
                             w_reads_rs1 = 1'b1; w_reads_rs2 = 1'b1; end
            c_OP_AND:  begin w_dec.valid = 1'b1; w_dec.wbs = 1'b1; w_dec.aluop = 2'b10;
                             w_reads_rs1 = 1'b1; w_reads_rs2 = 1'b1; end
            c_OP_OR:   begin w_dec.valid = 1'b1; w_dec.wbs = 1'b1; w_dec.aluop = 2'b11;
                             w_reads_rs1 = 1'b1; w_reads_rs2 = 1'b1; end
            c_OP_ADDI: begin w_dec.valid = 1'b1; w_dec.wbs = 1'b1; w_dec.am = 1'b1;
                             w_reads_rs1 = 1'b1; end
            c_OP_LDR:  begin w_dec.valid = 1'b1; w_dec.wbs = 1'b1; w_dec.mm = 1'b1;
                             w_dec.am = 1'b1; w_reads_rs1 = 1'b1; end
            c_OP_STR:  begin w_dec.valid = 1'b1; w_dec.wme = 1'b1; w_dec.am = 1'b1;
                             w_reads_rs1 = 1'b1; w_reads_rs2 = 1'b1; end
            c_OP_B:    begin w_dec.valid = 1'b1; w_dec.ni = 1'b1; w_dec.am = 1'b1; end
            c_OP_LDR2: begin w_dec.valid = 1'b1; w_dec.wbs = 1'b1; w_dec.mm = 1'b1;
                             w_dec.wm = 1'b1; w_dec.am = 1'b1; w_reads_rs1 = 1'b1; end
            default:   ; // NOP and illegal opcodes decode to a bubble
        endcase
        // Bubbles must carry all-zero fields, so fields only pass for real ops
        if (w_dec.valid) begin
            w_dec.rd  = w_rd;
            w_dec.rs1 = w_rs1;
            w_dec.rs2 = w_rs2;
            w_dec.imm = w_imm;
        end
    end

    assign w_hazard = r_out.valid & r_out.mm & (r_out.rd != '0) &
                      ((w_reads_rs1 & (w_rs1 == r_out.rd)) |
                       (w_reads_rs2 & (w_rs2 == r_out.rd)));

    assign w_in_ready     = ~flush & ~ex_stall & (r_state == S_RUN) & ~w_hazard;
    assign fetch.in_ready = w_in_ready;
    assign w_accept       = fetch.in_valid & w_in_ready;

    // Second LDR2 beat derives from the first, which is still on the outputs
    always_comb begin
        w_beat2     = r_out;
        w_beat2.rd  = r_out.rd + REG_AW'(1);
        w_beat2.imm = r_out.imm + IMM_W'(4);
    end

`ifdef DCU_ILLEGAL_TRAP_EN
    logic w_set_illegal;
    logic r_illegal;
`endif

    always_comb begin
        w_out_nxt   = r_out;
        w_state_nxt = r_state;
`ifdef DCU_ILLEGAL_TRAP_EN
        w_set_illegal = 1'b0;
`endif
        if (flush) begin
            w_out_nxt = '0;
`ifdef DCU_ILLEGAL_TRAP_EN
            if (r_state != S_TRAP) w_state_nxt = S_RUN;
`else
            w_state_nxt = S_RUN;
`endif
        end else if (!ex_stall) begin
            case (r_state)
                S_SECOND: begin
                    w_out_nxt   = w_beat2;
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    w_out_nxt = w_accept ? w_dec : '0;
                    if (w_accept && (w_opc == c_OP_LDR2)) w_state_nxt = S_SECOND;
`ifdef DCU_ILLEGAL_TRAP_EN
                    if (w_accept && (w_opc > c_OP_OR)) begin
                        w_state_nxt   = S_TRAP;
                        w_set_illegal = 1'b1;
                    end
`endif
                end
                default: w_out_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
        end
    end

`ifdef DCU_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                r_illegal <= 1'b0;
        else if (w_set_illegal) r_illegal <= 1'b1;
    end
    assign illegal_o = r_illegal;
`else
    assign illegal_o = 1'b0;
`endif

    assign valid_out = r_out.valid;
    assign wbs_out   = r_out.wbs;
    assign wme_out   = r_out.wme;
    assign mm_out    = r_out.mm;
    assign ALUop_out = r_out.aluop;
    assign wm_out    = r_out.wm;
    assign am_out    = r_out.am;
    assign ni_out    = r_out.ni;
    assign rd_out    = r_out.rd;
    assign rs1_out   = r_out.rs1;
    assign rs2_out   = r_out.rs2;
    assign imm_out   = r_out.imm;

endmodule
`default_nettype wire

// File: tb/tb_decode_control_issue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_decode_control_issue                                  |
// | Brief  : Directed + random bench for decode_control_issue with a  |
// |          micro-op queue reference model.                          |
// | Rev    : 1.0  initial release                                     |
// +------------------------------------------------------------------+
module tb_decode_control_issue;

    typedef struct packed {
        logic       v;
        logic       wbs;
        logic       wme;
        logic       mm;
        logic [1:0] alu;
        logic       wm;
        logic       am;
        logic       ni;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [15:0] imm;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_stall;
    logic        flush;
    logic        valid_out, wbs_out, wme_out, mm_out, wm_out, am_out, ni_out, illegal_o;
    logic [1:0]  ALUop_out;
    logic [3:0]  rd_out, rs1_out, rs2_out;
    logic [15:0] imm_out;
    op_t         w_dut;

    decode_control_issue_if #(.INSTR_W(32)) fif ();

    decode_control_issue #(.INSTR_W(32), .REG_AW(4), .IMM_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch     (fif.slave),
        .ex_stall  (ex_stall),
        .flush     (flush),
        .valid_out (valid_out),
        .wbs_out   (wbs_out),
        .wme_out   (wme_out),
        .mm_out    (mm_out),
        .ALUop_out (ALUop_out),
        .wm_out    (wm_out),
        .am_out    (am_out),
        .ni_out    (ni_out),
        .rd_out    (rd_out),
        .rs1_out   (rs1_out),
        .rs2_out   (rs2_out),
        .imm_out   (imm_out),
        .illegal_o (illegal_o)
    );

    always #5 clk = ~clk;

    assign w_dut = {valid_out, wbs_out, wme_out, mm_out, ALUop_out, wm_out, am_out, ni_out,
                    rd_out, rs1_out, rs2_out, imm_out};

    op_t m_out;
    op_t pend[$];
    bit  m_trap;
    bit  m_ill;
    int  total = 0;
    int  bad   = 0;

    function automatic op_t decode(logic [31:0] w);
        op_t o;
        o = '0;
        case (w[31:28])
            4'd1: o.wbs = 1'b1;
            4'd2: begin o.wbs = 1'b1; o.alu = 2'b01; end
            4'd3: begin o.wbs = 1'b1; o.alu = 2'b10; end
            4'd9: begin o.wbs = 1'b1; o.alu = 2'b11; end
            4'd4: begin o.wbs = 1'b1; o.am = 1'b1; end
            4'd5: begin o.wbs = 1'b1; o.mm = 1'b1; o.am = 1'b1; end
            4'd6: begin o.wme = 1'b1; o.am = 1'b1; end
            4'd7: begin o.ni = 1'b1; o.am = 1'b1; end
            4'd8: begin o.wbs = 1'b1; o.mm = 1'b1; o.wm = 1'b1; o.am = 1'b1; end
            default: ;
        endcase
        o.v = (w[31:28] inside {[4'd1:4'd9]});
        if (o.v) begin
            o.rd  = w[27:24];
            o.rs1 = w[23:20];
            o.rs2 = w[19:16];
            o.imm = w[15:0];
        end
        return o;
    endfunction

    function automatic bit hazard(op_t cur, logic [31:0] w);
        bit r1;
        bit r2;
        r1 = w[31:28] inside {[4'd1:4'd6], 4'd8, 4'd9};
        r2 = w[31:28] inside {[4'd1:4'd3], 4'd6, 4'd9};
        return cur.v && cur.mm && (cur.rd != 4'd0) &&
               ((r1 && (w[23:20] == cur.rd)) || (r2 && (w[19:16] == cur.rd)));
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out  = '0;
        pend.delete();
        m_trap = 1'b0;
        m_ill  = 1'b0;
    endtask

    // One clock: drive, check in_ready, advance model over the edge, check outputs
    task automatic cycle(bit iv, logic [31:0] ins, bit st, bit fl);
        bit  exp_rdy;
        bit  acc;
        op_t d;
        op_t b2;
        fif.in_valid = iv;
        fif.instr    = ins;
        ex_stall     = st;
        flush        = fl;
        #1;
        exp_rdy = !fl && !st && (pend.size() == 0) && !m_trap && !hazard(m_out, ins);
        check("in_ready", 64'(fif.in_ready), 64'(exp_rdy));
        acc = iv && exp_rdy;
        @(posedge clk);
        if (fl) begin
            m_out = '0;
            pend.delete();
        end else if (!st) begin
            if (pend.size() > 0) begin
                m_out = pend.pop_front();
            end else if (acc) begin
                d     = decode(ins);
                m_out = d;
                if (ins[31:28] == 4'd8) begin
                    b2     = d;
                    b2.rd  = d.rd + 4'd1;
                    b2.imm = d.imm + 16'd4;
                    pend.push_back(b2);
                end
`ifdef DCU_ILLEGAL_TRAP_EN
                if (ins[31:28] >= 4'd10) begin
                    m_trap = 1'b1;
                    m_ill  = 1'b1;
                end
`endif
            end else begin
                m_out = '0;
            end
        end
        #1;
        check("bundle", 64'(w_dut), 64'(m_out));
        check("illegal", 64'(illegal_o), 64'(m_ill));
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        fif.in_valid = 1'b0;
        fif.instr    = '0;
        ex_stall     = 1'b0;
        flush        = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_bundle", 64'(w_dut), 64'(m_out));
        check("rst_ready", 64'(fif.in_ready), 64'(1'b1));
        check("rst_illegal", 64'(illegal_o), 64'(1'b0));
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        do_reset();

        cycle(1'b1, 32'h1312_0000, 1'b0, 1'b0);
        check("add_bundle", 64'(w_dut),
              64'({1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd3, 4'd1, 4'd2, 16'd0}));

        // Load-use on r4, then the same pattern through r0 (no hazard)
        cycle(1'b1, 32'h5410_0008, 1'b0, 1'b0);
        cycle(1'b1, 32'h1542_0000, 1'b0, 1'b0);
        check("hazard_bubble", 64'(valid_out), 64'(1'b0));
        cycle(1'b1, 32'h1542_0000, 1'b0, 1'b0);
        check("after_bubble_rd", 64'(rd_out), 64'(4'd5));
        cycle(1'b1, 32'h5010_0008, 1'b0, 1'b0);
        cycle(1'b1, 32'h1502_0000, 1'b0, 1'b0);
        check("rd0_no_bubble", 64'(valid_out), 64'(1'b1));

        // LDR2 wrap-around of rd and imm
        cycle(1'b1, 32'h8F20_FFFE, 1'b0, 1'b0);
        check("ldr2_b1", 64'({rd_out, imm_out, wm_out}), 64'({4'd15, 16'hFFFE, 1'b1}));
        cycle(1'b1, 32'h1312_0000, 1'b0, 1'b0);
        check("ldr2_b2", 64'({rd_out, imm_out, wm_out}), 64'({4'd0, 16'h0002, 1'b1}));
        cycle(1'b1, 32'h1312_0000, 1'b0, 1'b0);

        // Three stall cycles mid-stream
        cycle(1'b1, 32'h2312_0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3312_0000, 1'b1, 1'b0);
        cycle(1'b1, 32'h3312_0000, 1'b0, 1'b0);
        check("after_stall_alu", 64'(ALUop_out), 64'(2'b10));

        // Flush kills pending LDR2 beat 2
        cycle(1'b1, 32'h8320_0010, 1'b0, 1'b0);
        cycle(1'b0, 32'h0000_0000, 1'b0, 1'b1);
        check("flush_bubble", 64'(valid_out), 64'(1'b0));
        cycle(1'b1, 32'h4312_0005, 1'b0, 1'b0);
        check("post_flush_issue", 64'({valid_out, am_out}), 64'({1'b1, 1'b1}));

        // Asynchronous reset while beat 2 is pending
        cycle(1'b1, 32'h8320_0010, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check("async_rst", 64'(w_dut), 64'(0));
        #2 rst = 1'b0;
        model_reset();
        cycle(1'b0, 32'h0000_0000, 1'b0, 1'b0);

        for (int i = 0; i < 500; i++) begin
            logic [31:0] ins;
            ins = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 16'($urandom)};
            cycle($urandom_range(0, 9) < 8, ins, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 19) == 0);
        end

        cycle(1'b1, 32'hC123_4567, 1'b0, 1'b0);
        check("illegal_bubble", 64'(valid_out), 64'(1'b0));
`ifdef DCU_ILLEGAL_TRAP_EN
        check("illegal_set", 64'(illegal_o), 64'(1'b1));
        cycle(1'b1, 32'h1312_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'h1312_0000, 1'b0, 1'b1);
        cycle(1'b1, 32'h1312_0000, 1'b0, 1'b0);
        check("trap_ready", 64'(fif.in_ready), 64'(1'b0));
        do_reset();
        cycle(1'b1, 32'h1312_0000, 1'b0, 1'b0);
`else
        cycle(1'b1, 32'h1312_0000, 1'b0, 1'b0);
`endif
        check("after_illegal", 64'(valid_out), 64'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
